serial_compare_ctrl: RTL

//  Sequencer that time-shares one 2-bit compare slice to do an unsigned magnitude

---
 rtl/serial_compare_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/serial_compare_ctrl.sv
// Bit-serial unsigned magnitude compare: one 2-bit slice shared across WIDTH/2 pairs, MSB pair first.
// Build option: define EARLY_EXIT_EN to finish as soon as the first unequal pair decides the result.
module serial_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq_out,
  output logic             lt_out,
  output logic             gt_out
);

  localparam int NP = WIDTH / 2;
  localparam int IW = (NP > 1) ? $clog2(NP) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateType;

  stateType         stateReg, stateNext;
  logic [WIDTH-1:0] aReg, aNext;
  logic [WIDTH-1:0] bReg, bNext;
  logic             eqReg, eqNext;
  logic             ltReg, ltNext;
  logic [IW-1:0]    idxReg, idxNext;
  logic             eqOutReg, eqOutNext;
  logic             ltOutReg, ltOutNext;
  logic             gtOutReg, gtOutNext;

  logic [1:0] aPair [NP];
  logic [1:0] bPair [NP];
  logic [1:0] pairA, pairB;
  logic       sliceEq, sliceLt;
  logic       exitNow;

  genvar gi;
  generate
    for (gi = 0; gi < NP; gi++) begin : gPair
      assign aPair[gi] = aReg[2*gi +: 2];
      assign bPair[gi] = bReg[2*gi +: 2];
    end
  endgenerate

  // Shared compare slice: once an earlier pair differed, the decision is frozen.
  assign pairA   = aPair[idxReg];
  assign pairB   = bPair[idxReg];
  assign sliceEq = eqReg & (pairA == pairB);
  assign sliceLt = eqReg ? (pairA < pairB) : ltReg;

`ifdef EARLY_EXIT_EN
  assign exitNow = ~sliceEq;
`else
  assign exitNow = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
      aReg     <= '0;
      bReg     <= '0;
      eqReg    <= 1'b0;
      ltReg    <= 1'b0;
      idxReg   <= '0;
      eqOutReg <= 1'b0;
      ltOutReg <= 1'b0;
      gtOutReg <= 1'b0;
    end else begin
      stateReg <= stateNext;
      aReg     <= aNext;
      bReg     <= bNext;
      eqReg    <= eqNext;
      ltReg    <= ltNext;
      idxReg   <= idxNext;
      eqOutReg <= eqOutNext;
      ltOutReg <= ltOutNext;
      gtOutReg <= gtOutNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    aNext     = aReg;
    bNext     = bReg;
    eqNext    = eqReg;
    ltNext    = ltReg;
    idxNext   = idxReg;
    eqOutNext = eqOutReg;
    ltOutNext = ltOutReg;
    gtOutNext = gtOutReg;
    unique case (stateReg)
      IDLE: begin
        if (start) begin
          aNext     = a;
          bNext     = b;
          eqNext    = 1'b1;
          ltNext    = 1'b0;
          idxNext   = IW'(NP - 1);
          stateNext = RUN;
        end
      end
      RUN: begin
        eqNext = sliceEq;
        ltNext = sliceLt;
        if (idxReg == '0 || exitNow) begin
          // Results are loaded with the final chain value so they are valid while done is high.
          eqOutNext = sliceEq;
          ltOutNext = sliceLt;
          gtOutNext = ~sliceEq & ~sliceLt;
          stateNext = DONE;
        end else begin
          idxNext = idxReg - IW'(1);
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign busy   = (stateReg == RUN) || (stateReg == DONE);
  assign done   = (stateReg == DONE);
  assign eq_out = eqOutReg;
  assign lt_out = ltOutReg;
  assign gt_out = gtOutReg;

endmodule
